// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter, registered grant (1-cycle req->gnt), hold timeout rotation after HOLD_MAX+1 cycles.
// No backpressure: req is level-sensitive and never latched; define LOCK_EN to add a lock input that suppresses timeout rotation.
module rr_arbiter_8 #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       req,
`ifdef LOCK_EN
  input  logic             lock,
`endif
  output logic [7:0]       gnt,
  output logic [2:0]       gnt_idx,
  output logic             gnt_valid,
  output logic [CNT_W-1:0] hold_cnt
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;
  localparam logic [CNT_W-1:0] HOLD_MAX_C = CNT_W'(HOLD_MAX);

  logic [0:0]       state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       gnt_idx_q, gnt_idx_d;
  logic [7:0]       gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;

  logic             hold_lock;
  logic [7:0]       others;
  logic [2:0]       win_idle;
  logic [2:0]       win_next;
  logic [CNT_W-1:0] hold_inc;

`ifdef LOCK_EN
  assign hold_lock = lock;
`else
  assign hold_lock = 1'b0;
`endif

  // First set bit of r searching base+1, base+2, ... wrapping modulo 8.
  function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    pick  = base;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = base + 3'(k);
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  endfunction

  assign others   = req & ~(8'd1 << gnt_idx_q);
  assign win_idle = pick(req, ptr_q);
  assign win_next = pick(others, gnt_idx_q);
  assign hold_inc = (hold_cnt_q == HOLD_MAX_C) ? HOLD_MAX_C : hold_cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    hold_cnt_d  = hold_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 8'd0) begin
          state_d     = ST_GRANT;
          ptr_d       = win_idle;
          gnt_idx_d   = win_idle;
          gnt_d       = 8'd1 << win_idle;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = '0;
        end
      end
      default: begin
        if (!req[gnt_idx_q]) begin
          if (others != 8'd0) begin
            ptr_d      = win_next;
            gnt_idx_d  = win_next;
            gnt_d      = 8'd1 << win_next;
            hold_cnt_d = '0;
          end else begin
            // ptr keeps the released owner so it gets lowest priority next time
            state_d     = ST_IDLE;
            gnt_idx_d   = 3'd0;
            gnt_d       = 8'd0;
            gnt_valid_d = 1'b0;
            hold_cnt_d  = '0;
          end
        end else if (others == 8'd0 || hold_cnt_q < HOLD_MAX_C || hold_lock) begin
          hold_cnt_d = hold_inc;
        end else begin
          ptr_d      = win_next;
          gnt_idx_d  = win_next;
          gnt_d      = 8'd1 << win_next;
          hold_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 3'd7;
      gnt_idx_q   <= 3'd0;
      gnt_q       <= 8'd0;
      gnt_valid_q <= 1'b0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
  assign hold_cnt  = hold_cnt_q;

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-way round-robin arbiter sharing one resource slot among eight requesters; the granted requester is identified by a 3-bit index, and that index is also presented decoded to one-hot.
- Registered grant, bounded hold time and fair rotation.
- Sits in front of any shared 8-client resource, e.g. a bus, a memory port or a display digit driver.

Parameters:
- HOLD_MAX, 15, max consecutive cycles one grant may be held while other requests are pending (1..2^CNT_W-1).
- CNT_W, 4, width of hold counter.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous active-high reset.
- req  input  8  request vector, bit i = requester i; level-sensitive.
- gnt  output  8  one-hot grant, registered; all-zero when idle.
- gnt_idx  output  3  binary index of current grant; 0 when idle.
- gnt_valid  output  1  high when any grant is active.
- hold_cnt  output  CNT_W  cycles current grant has been held; 0 when idle.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high; all outputs are registered.
- Reset (rst=1 at a rising edge):
  - gnt=8'h00, gnt_idx=3'd0, gnt_valid=0, hold_cnt=0, state=IDLE.
  - Internal last-served pointer ptr=3'd7, so requester 0 has top priority first.
- Reset mid-grant drops the grant on the next edge with no completion cycle.
- Arbitration: search order starts at ptr+1 and wraps modulo 8 (ptr=7 -> 0,1,..,7). The winner is the first set bit of req in that order.
- States:
  - IDLE:
    - if req!=0, then next edge: state=GRANT, gnt_idx=winner, gnt=1<<winner, gnt_valid=1, hold_cnt=0, ptr=winner.
    - otherwise remain in IDLE.
    - Latency from req assertion to gnt is exactly 1 cycle.
  - GRANT, owner o=gnt_idx:
    - if req[o]=0 (released):
      - if other requests are pending, switch to the next winner the same edge, with hold_cnt=0;
      - otherwise go to IDLE with outputs at reset values, ptr unchanged.
      - No dead cycle between consecutive grants.
    - if req[o]=1 and no other bit set: keep the grant; hold_cnt saturates at HOLD_MAX and does not wrap.
    - if req[o]=1, another bit is set and hold_cnt<HOLD_MAX: keep the grant, hold_cnt+1.
    - if req[o]=1, another bit is set and hold_cnt==HOLD_MAX: forced rotation to the next winner, which excludes o, with hold_cnt=0.
    - Maximum tenure under contention is HOLD_MAX+1 cycles.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt == (gnt_valid ? 1<<gnt_idx : 0).
  - A requester holding req high waits at most 7*(HOLD_MAX+1) cycles for a grant.
- Simultaneous events:
  - Owner release together with new requests: the new winner is picked from ptr=o, so o gets lowest priority.
  - Requests that drop before being granted are simply not served; they are not latched.

Optional Feature:
- Macro LOCK_EN.
- Defined:
  - Adds input port lock (1 bit).
  - While gnt_valid=1 and lock=1, forced rotation is suppressed: the owner keeps the grant until req[o]=0, and hold_cnt still saturates at HOLD_MAX.
  - lock has no effect in IDLE.
- Not defined: the port is absent and timeout rotation always applies.

Test Plan:
- Reset/idle: rst=1 for 2 cycles, then req=0 for 5 cycles -> gnt=00, gnt_idx=0, gnt_valid=0, hold_cnt=0 throughout.
- Single request and latency: req=8'h10 at cycle t -> gnt=8'h10, gnt_idx=4 at t+1; req drops at t+3 -> gnt=00 at t+4.
- Round robin: req=8'hFF held, each owner dropping its bit for one cycle after 2 cycles of grant -> grant order 0,1,2,...,7,0, wrapping with no idle cycles.
- Timeout: req=8'h05 held continuously, HOLD_MAX=15 -> idx 0 granted for 16 cycles (hold_cnt 0..15), then idx 2 for 16 cycles, then idx 0 again.
- Release plus contention: owner 6 drops as req=8'h41 changes to 8'h01 -> next edge gnt=8'h01 with hold_cnt=0; then req=0 -> IDLE.
- Reset mid-grant and lock: during grant of idx 3 assert rst -> next edge all outputs zero and the next request from 0 is served first. With LOCK_EN, req=8'h03 and lock=1 -> idx 0 held 40 cycles with hold_cnt stuck at 15; lock=0 -> rotation to idx 1 on the next edge.
